// File: rtl/i2c_target_rw.sv
// I2C target with write/read transfers, repeated START, address masking, optional SCL stretching.
// Latency: SYNC_DEPTH clk from pad edge to detect, all outputs registered one cycle later.
// Backpressure: read data via tx_valid/tx_ready; STRETCH_EN=1 holds SCL low until a byte is accepted.
module i2c_target_rw #(
    parameter logic [6:0] I2C_ADDR   = 7'h28,
    parameter logic [6:0] ADDR_MASK  = 7'h7F,
    parameter int         SYNC_DEPTH = 3,
    parameter bit         STRETCH_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic       bus_active,
    output logic       addressed,
    output logic       rd_mode
);
    typedef enum logic [2:0] {IDLE, ADDR, AACK, WDATA, WACK, RDATA, RACK, IGNORE} state_t;

    state_t                state;
    logic [SYNC_DEPTH-1:0] scl_sync;
    logic [SYNC_DEPTH-1:0] sda_sync;
    logic [7:0]            shreg;
    logic [3:0]            bit_cnt;
    logic                  first_arm;
    logic                  scl_rel;
    logic                  got_ack;

    logic scl_lvl, sda_lvl, scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_det, stop_det, addr_match;

    assign scl_lvl    = scl_sync[SYNC_DEPTH-1];
    assign sda_lvl    = sda_sync[SYNC_DEPTH-1];
    assign scl_rise   = ~scl_sync[SYNC_DEPTH-1] &  scl_sync[SYNC_DEPTH-2];
    assign scl_fall   =  scl_sync[SYNC_DEPTH-1] & ~scl_sync[SYNC_DEPTH-2];
    assign sda_rise   = ~sda_sync[SYNC_DEPTH-1] &  sda_sync[SYNC_DEPTH-2];
    assign sda_fall   =  sda_sync[SYNC_DEPTH-1] & ~sda_sync[SYNC_DEPTH-2];
    assign start_det  = sda_fall & scl_lvl;
    assign stop_det   = sda_rise & scl_lvl;
    assign addr_match = ((shreg[7:1] & ADDR_MASK) == (I2C_ADDR & ADDR_MASK));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            scl_sync    <= '1;
            sda_sync    <= '1;
            shreg       <= 8'h00;
            bit_cnt     <= 4'd0;
            first_arm   <= 1'b0;
            scl_rel     <= 1'b0;
            got_ack     <= 1'b0;
            scl_oe      <= 1'b0;
            sda_oe      <= 1'b0;
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
            rx_first    <= 1'b0;
            tx_ready    <= 1'b0;
            tx_underrun <= 1'b0;
            bus_active  <= 1'b0;
            addressed   <= 1'b0;
            rd_mode     <= 1'b0;
        end else begin
            scl_sync    <= {scl_sync[SYNC_DEPTH-2:0], scl_in};
            sda_sync    <= {sda_sync[SYNC_DEPTH-2:0], sda_in};
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            // Bus conditions override every edge event, including a pending tx transfer.
            if (stop_det || start_det) begin
                state      <= stop_det ? IDLE : ADDR;
                bus_active <= start_det;
                bit_cnt    <= 4'd0;
                addressed  <= 1'b0;
                rd_mode    <= 1'b0;
                scl_oe     <= 1'b0;
                sda_oe     <= 1'b0;
                tx_ready   <= 1'b0;
                scl_rel    <= 1'b0;
                got_ack    <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_lvl};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (addr_match) begin
                                sda_oe    <= 1'b1;
                                addressed <= 1'b1;
                                rd_mode   <= shreg[0];
                                state     <= AACK;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    AACK: begin
                        if (scl_fall) begin
                            sda_oe <= 1'b0;
                            if (rd_mode) begin
                                state    <= RDATA;
                                tx_ready <= 1'b1;
                                scl_oe   <= STRETCH_EN;
                            end else begin
                                state     <= WDATA;
                                bit_cnt   <= 4'd0;
                                first_arm <= 1'b1;
                            end
                        end
                    end
                    WDATA: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            shreg   <= {shreg[6:0], sda_lvl};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                rx_byte   <= {shreg[6:0], sda_lvl};
                                rx_valid  <= 1'b1;
                                rx_first  <= first_arm;
                                first_arm <= 1'b0;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            sda_oe <= 1'b1;
                            state  <= WACK;
                        end
                    end
                    WACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= WDATA;
                        end
                    end
                    RDATA: begin
                        if (tx_ready) begin
                            // Without stretching the byte must be taken now; an empty slot reads as 0xFF.
                            if (tx_valid || !STRETCH_EN) begin
                                shreg       <= tx_valid ? tx_byte : 8'hFF;
                                sda_oe      <= tx_valid ? ~tx_byte[7] : 1'b0;
                                tx_underrun <= ~tx_valid;
                                tx_ready    <= 1'b0;
                                bit_cnt     <= 4'd1;
                                scl_rel     <= STRETCH_EN;
                            end
                        end else begin
                            if (scl_rel) begin
                                scl_oe  <= 1'b0;
                                scl_rel <= 1'b0;
                            end
                            if (scl_fall) begin
                                if (bit_cnt == 4'd8) begin
                                    sda_oe  <= 1'b0;
                                    got_ack <= 1'b0;
                                    state   <= RACK;
                                end else begin
                                    shreg   <= {shreg[6:0], 1'b0};
                                    sda_oe  <= ~shreg[6];
                                    bit_cnt <= bit_cnt + 4'd1;
                                end
                            end
                        end
                    end
                    RACK: begin
                        if (scl_rise) begin
                            if (sda_lvl) state <= IGNORE;
                            else         got_ack <= 1'b1;
                        end else if (scl_fall && got_ack) begin
                            state    <= RDATA;
                            tx_ready <= 1'b1;
                            scl_oe   <= STRETCH_EN;
                        end
                    end
                    default: begin
                        scl_oe <= 1'b0;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_target_rw.sv
// Directed bench: bit-banged I2C master against a stretching exact-match target (a) and a masked non-stretching target (b).
module tb_i2c_target_rw;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic sel = 1'b0;

    logic       scl_oe_a, sda_oe_a, rx_valid_a, rx_first_a, tx_ready_a, tx_underrun_a;
    logic       bus_active_a, addressed_a, rd_mode_a;
    logic [7:0] rx_byte_a;
    logic [7:0] tx_byte_a = 8'h00;
    logic       tx_valid_a = 1'b0;
    logic       scl_oe_b, sda_oe_b, rx_valid_b, rx_first_b, tx_ready_b, tx_underrun_b;
    logic       bus_active_b, addressed_b, rd_mode_b;
    logic [7:0] rx_byte_b;
    logic [7:0] tx_byte_b = 8'h00;
    logic       tx_valid_b = 1'b0;

    wire scl_a = m_scl & ~scl_oe_a;
    wire sda_a = m_sda & ~sda_oe_a;
    wire scl_b = m_scl & ~scl_oe_b;
    wire sda_b = m_sda & ~sda_oe_b;
    wire bus_scl = sel ? scl_b : scl_a;
    wire bus_sda = sel ? sda_b : sda_a;

    wire [16:0] outs_a = {scl_oe_a, sda_oe_a, rx_byte_a, rx_valid_a, rx_first_a, tx_ready_a,
                          tx_underrun_a, bus_active_a, addressed_a, rd_mode_a};
    wire [16:0] outs_b = {scl_oe_b, sda_oe_b, rx_byte_b, rx_valid_b, rx_first_b, tx_ready_b,
                          tx_underrun_b, bus_active_b, addressed_b, rd_mode_b};

    i2c_target_rw #(.I2C_ADDR(7'h28), .ADDR_MASK(7'h7F), .SYNC_DEPTH(3), .STRETCH_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_a), .sda_in(sda_a), .scl_oe(scl_oe_a), .sda_oe(sda_oe_a),
        .rx_byte(rx_byte_a), .rx_valid(rx_valid_a), .rx_first(rx_first_a), .tx_byte(tx_byte_a),
        .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .tx_underrun(tx_underrun_a),
        .bus_active(bus_active_a), .addressed(addressed_a), .rd_mode(rd_mode_a));

    i2c_target_rw #(.I2C_ADDR(7'h28), .ADDR_MASK(7'h7E), .SYNC_DEPTH(4), .STRETCH_EN(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_b), .sda_in(sda_b), .scl_oe(scl_oe_b), .sda_oe(sda_oe_b),
        .rx_byte(rx_byte_b), .rx_valid(rx_valid_b), .rx_first(rx_first_b), .tx_byte(tx_byte_b),
        .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .tx_underrun(tx_underrun_b),
        .bus_active(bus_active_b), .addressed(addressed_b), .rd_mode(rd_mode_b));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [8:0] rx_q_a[$];
    logic [7:0] tx_q_a[$];
    int rx_cnt_b = 0, unr_cnt_b = 0, txr_cnt_b = 0, sda_oe_cnt_a = 0, xfers_a = 0;
    logic [7:0] rx_last_b = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid_a) rx_q_a.push_back({rx_first_a, rx_byte_a});
        if (rx_valid_b) begin rx_cnt_b++; rx_last_b = rx_byte_b; end
        if (tx_underrun_b) unr_cnt_b++;
        if (tx_ready_b) txr_cnt_b++;
        if (sda_oe_a) sda_oe_cnt_a++;
        if (tx_valid_a && tx_ready_a) xfers_a++;
    end

    // Read-data source for target a: after each accepted byte present the next queued one.
    initial forever begin
        @(negedge clk);
        if (rst_n && tx_valid_a && tx_ready_a) begin
            @(posedge clk); #1;
            if (tx_q_a.size() > 0) tx_byte_a = tx_q_a.pop_front();
            else                   tx_valid_a = 1'b0;
        end
    end

    task automatic wait_scl_high();
        int n = 0;
        while (bus_scl !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        if (bus_scl !== 1'b1) check("scl_release", bus_scl, 1'b1);
    endtask

    task automatic clk_bit(input logic b, output logic r);
        repeat (6) @(negedge clk); m_sda = b;
        repeat (6) @(negedge clk); m_scl = 1'b1;
        wait_scl_high();
        repeat (5) @(negedge clk); r = bus_sda;
        repeat (5) @(negedge clk); m_scl = 1'b0;
    endtask

    task automatic start_cond();
        repeat (6) @(negedge clk); m_sda = 1'b1;
        repeat (6) @(negedge clk); m_scl = 1'b1;
        wait_scl_high();
        repeat (8) @(negedge clk); m_sda = 1'b0;
        repeat (8) @(negedge clk); m_scl = 1'b0;
    endtask

    task automatic stop_cond();
        repeat (6) @(negedge clk); m_sda = 1'b0;
        repeat (6) @(negedge clk); m_scl = 1'b1;
        wait_scl_high();
        repeat (8) @(negedge clk); m_sda = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin clk_bit(1'b1, r); d[i] = r; end
        clk_bit(nack, r);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         held, n, k_sda, k_scl;

        repeat (5) @(negedge clk);
        check("reset_outs_a", outs_a, 17'h0);
        check("reset_outs_b", outs_b, 17'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Write 0x28: A5, 3C
        sel = 1'b0;
        rx_q_a.delete();
        start_cond();
        write_byte(8'h50, ack); check("w_addr_ack", ack, 1'b0);
        check("w_bus_active", bus_active_a, 1'b1);
        check("w_addressed", addressed_a, 1'b1);
        check("w_rd_mode", rd_mode_a, 1'b0);
        write_byte(8'hA5, ack); check("w_d1_ack", ack, 1'b0);
        write_byte(8'h3C, ack); check("w_d2_ack", ack, 1'b0);
        stop_cond();
        check("w_rx_count", rx_q_a.size(), 2);
        if (rx_q_a.size() == 2) begin
            check("w_rx0", rx_q_a[0], 9'h1A5);
            check("w_rx1", rx_q_a[1], 9'h03C);
        end
        check("w_idle_bus_active", bus_active_a, 1'b0);
        check("w_idle_addressed", addressed_a, 1'b0);

        // Address 0x29: a must ignore it, b (mask 7E) must accept it
        rx_q_a.delete();
        rx_cnt_b = 0;
        sda_oe_cnt_a = 0;
        sel = 1'b0;
        start_cond();
        write_byte(8'h52, ack); check("m_nack_a", ack, 1'b1);
        write_byte(8'h66, ack);
        stop_cond();
        check("m_sda_oe_a", sda_oe_cnt_a, 0);
        check("m_rx_a", rx_q_a.size(), 0);
        sel = 1'b1;
        rx_cnt_b = 0;
        start_cond();
        write_byte(8'h52, ack); check("m_ack_b", ack, 1'b0);
        write_byte(8'h77, ack); check("m_d_ack_b", ack, 1'b0);
        stop_cond();
        check("m_rx_cnt_b", rx_cnt_b, 1);
        check("m_rx_byte_b", rx_last_b, 8'h77);

        // Read C3, 81 with tx_valid held
        sel = 1'b0;
        xfers_a = 0;
        tx_byte_a = 8'hC3;
        tx_valid_a = 1'b1;
        tx_q_a.push_back(8'h81);
        start_cond();
        write_byte(8'h51, ack); check("r_addr_ack", ack, 1'b0);
        read_byte(1'b0, d); check("r_byte1", d, 8'hC3);
        read_byte(1'b1, d); check("r_byte2", d, 8'h81);
        repeat (20) @(negedge clk);
        check("r_ign_tx_ready", tx_ready_a, 1'b0);
        check("r_ign_sda_oe", sda_oe_a, 1'b0);
        stop_cond();
        check("r_xfers", xfers_a, 2);

        // Clock stretching while read data arrives 50 cycles late
        held = 0; k_sda = -1; k_scl = -1;
        tx_valid_a = 1'b0;
        fork
            begin
                start_cond();
                write_byte(8'h51, ack);
                read_byte(1'b1, d);
                stop_cond();
            end
            begin
                n = 0;
                while (tx_ready_a !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
                check("s_tx_ready", tx_ready_a, 1'b1);
                repeat (50) begin @(negedge clk); if (scl_oe_a) held++; end
                @(posedge clk); #1;
                tx_byte_a = 8'h5A;
                tx_valid_a = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k_sda < 0 && sda_oe_a) k_sda = k;
                    if (k_scl < 0 && !scl_oe_a) k_scl = k;
                end
            end
        join
        check("s_held", held, 50);
        check("s_sda_set_cycle", k_sda, 1);
        check("s_scl_rel_cycle", k_scl, 2);
        check("s_byte", d, 8'h5A);

        // Underrun on the non-stretching target
        sel = 1'b1;
        unr_cnt_b = 0;
        txr_cnt_b = 0;
        start_cond();
        write_byte(8'h53, ack); check("u_addr_ack", ack, 1'b0);
        read_byte(1'b1, d); check("u_byte", d, 8'hFF);
        stop_cond();
        check("u_underruns", unr_cnt_b, 1);
        check("u_tx_ready_cycles", txr_cnt_b, 1);

        // Write 0x11, repeated START, read, then reset mid-byte
        sel = 1'b0;
        rx_q_a.delete();
        start_cond();
        write_byte(8'h50, ack);
        write_byte(8'h11, ack);
        start_cond();
        write_byte(8'h51, ack); check("rs_addr_ack", ack, 1'b0);
        check("rs_rx_count", rx_q_a.size(), 1);
        if (rx_q_a.size() == 1) check("rs_rx0", rx_q_a[0], 9'h111);
        repeat (10) @(negedge clk);
        check("rs_rd_mode", rd_mode_a, 1'b1);
        check("rs_tx_ready", tx_ready_a, 1'b1);
        check("rs_scl_oe", scl_oe_a, 1'b1);
        tx_byte_a = 8'h00;
        tx_valid_a = 1'b1;
        for (int i = 0; i < 3; i++) clk_bit(1'b1, ack);
        repeat (6) @(negedge clk);
        check("rs_sda_driven", sda_oe_a, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_outs_a", outs_a, 17'h0);
        check("rst_outs_b", outs_b, 17'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
